// File: rtl/ivbus_fifo_port.sv
// rtl/ivbus_fifo_port.sv - 8X305 IV-bus peripheral with buffered TX/RX byte FIFOs
// Optional irq enable register and irq output are built when IVPORT_IRQ_EN is defined.
module ivbus_fifo_port #(
  parameter int         BANK       = 0,
  parameter logic [7:0] BASE_ADDR  = 8'h10,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire  [7:0] iv,
  input  logic       lb,
  input  logic       rb,
  input  logic       sc,
  input  logic       wc,
  input  logic       mclk,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       irq
);
  localparam int            DEPTH    = 1 << DEPTH_LOG2;
  localparam int            CW       = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // The bus is active-low and bit-reversed; this mapping is its own inverse.
  function automatic logic [7:0] iv_swap(input logic [7:0] v);
    return ~{v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  logic [7:0]            addr_q, addr_d;
  logic                  mclk_d_q, mclk_d_d;
  logic                  tx_drop_q, tx_drop_d;
  logic [DEPTH_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [DEPTH_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]            tx_mem_q [DEPTH];
  logic [7:0]            rx_mem_q [DEPTH];

  logic       en, sel_data, sel_stat, sel_ctrl, sel, bus_wr, bus_rd;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       irq_en;
  logic [3:0] rx_cnt_sat;
  logic [7:0] din, rx_head, rd_byte;

  assign en       = (BANK != 0) ? ~rb : ~lb;
  assign din      = iv_swap(iv);
  assign sel_data = (addr_q == BASE_ADDR);
  assign sel_stat = (addr_q == BASE_ADDR + 8'd1);
  assign sel_ctrl = (addr_q == BASE_ADDR + 8'd2);
  assign sel      = sel_data | sel_stat | sel_ctrl;
  assign bus_wr   = mclk & wc & en & sel;
  assign bus_rd   = en & ~sc & ~wc & sel;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);

  // Acceptance always uses the pre-edge counts, so a full RX never takes a
  // byte even when the core pops in the same cycle.
  assign tx_push = bus_wr & sel_data & ~tx_full;
  assign tx_pop  = ~tx_empty & tx_ready;
  assign rx_push = rx_valid & ~rx_full;
  assign rx_pop  = mclk_d_q & bus_rd & sel_data & ~rx_empty;

  always_comb begin
    addr_d    = addr_q;
    mclk_d_d  = mclk;
    tx_drop_d = tx_drop_q;
    if (mclk && sc && en) addr_d = din;
    if (bus_wr && sel_data && tx_full)    tx_drop_d = 1'b1;
    else if (bus_wr && sel_ctrl && din[1]) tx_drop_d = 1'b0;
    tx_wp_d  = tx_wp_q + DEPTH_LOG2'(tx_push);
    tx_rp_d  = tx_rp_q + DEPTH_LOG2'(tx_pop);
    rx_wp_d  = rx_wp_q + DEPTH_LOG2'(rx_push);
    rx_rp_d  = rx_rp_q + DEPTH_LOG2'(rx_pop);
    tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
    rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q    <= '0;
      mclk_d_q  <= 1'b0;
      tx_drop_q <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
    end else begin
      addr_q    <= addr_d;
      mclk_d_q  <= mclk_d_d;
      tx_drop_q <= tx_drop_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
    end
  end

  // Storage is left unreset; empty FIFOs present 8'h00 instead of stale data.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= din;
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_data;
  end

`ifdef IVPORT_IRQ_EN
  logic irq_en_q, irq_en_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (bus_wr && sel_ctrl) irq_en_d = din[0];
  end

  always_ff @(posedge clk) begin
    if (!reset) irq_en_q <= 1'b0;
    else        irq_en_q <= irq_en_d;
  end

  assign irq_en = irq_en_q;
`else
  assign irq_en = 1'b0;
`endif

  assign irq        = irq_en & ~rx_empty;
  assign tx_valid   = ~tx_empty;
  assign rx_ready   = ~rx_full;
  assign tx_data    = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];
  assign rx_head    = rx_empty ? 8'h00 : rx_mem_q[rx_rp_q];
  assign rx_cnt_sat = (32'(rx_cnt_q) > 32'd15) ? 4'hF : 4'(rx_cnt_q);

  always_comb begin
    rd_byte = 8'h00;
    if (sel_data)      rd_byte = rx_head;
    else if (sel_stat) rd_byte = {rx_cnt_sat, ~rx_empty, tx_drop_q, ~tx_full, ~rx_empty};
    else if (sel_ctrl) rd_byte = {7'b0, irq_en};
  end

  assign iv = bus_rd ? iv_swap(rd_byte) : 8'bz;

endmodule
